dec_scan_seq: RTL and testbench

- Sequential index generator that sits directly upstream of the 3-to-8 decoder and drives its 3-bit select input, X.
- It steps the select value through 0..limit under a prescaled tick.
- Supports up/down direction, continuous or one-shot sweeps, pause and synchronous load.
- Used to scan 8-way one-hot loads such as display digits and LED columns.

---
 rtl/dec_scan_seq.sv | 136 +++++++++++++
 tb/tb_dec_scan_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_seq.sv
// Prescaled select-index generator that feeds a 3-to-8 decoder.
// Sweeps X over 0..limit (up or down) with pause, one-shot, stop and load.
module dec_scan_seq #(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic [SEL_W-1:0] limit,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] X,
  output logic             valid,
  output logic             step,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int              PW       = 16;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] x_q, x_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             os_q, os_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic [SEL_W-1:0] nxt_x;
  logic             nxt_wrap;

  // Next index for a tick; an out-of-range X recovers to 0 (up) or limit (down).
  always_comb begin
    nxt_x    = x_q;
    nxt_wrap = 1'b0;
    if (!dir) begin
      if (x_q >= limit) begin
        nxt_x    = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_x = x_q + SEL_W'(1);
      end
    end else begin
      if (x_q == '0) begin
        nxt_x    = limit;
        nxt_wrap = 1'b1;
      end else if (x_q > limit) begin
        nxt_x = limit;
      end else begin
        nxt_x = x_q - SEL_W'(1);
      end
    end
  end

  // Priority: stop > load > start > tick.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    pre_d   = pre_q;
    os_d    = os_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (load) begin
      x_d   = load_val;
      pre_d = '0;
      if (state_q == DONE) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            x_d     = dir ? limit : '0;
            pre_d   = '0;
            os_d    = oneshot;
          end
        end
        RUN: begin
          if (en) begin
            if (pre_q == PRE_LAST) begin
              pre_d  = '0;
              x_d    = nxt_x;
              step_d = 1'b1;
              wrap_d = nxt_wrap;
              if (os_q && nxt_wrap) state_d = DONE;
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      pre_q   <= '0;
      os_q    <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pre_q   <= pre_d;
      os_q    <= os_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign X         = x_q;
  assign valid     = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed bench for dec_scan_seq: hand-computed expectations per cycle.
// A second instance with PRESCALE=1 covers the every-cycle tick case.
module tb_dec_scan_seq;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic       clk;
  logic       rst;
  logic       start, stop, en, dir, oneshot, load;
  logic [2:0] limit, load_val;
  logic [2:0] x;
  logic       valid, step, wrap, done;
  logic [1:0] state_dbg;

  logic       b_start, b_stop, b_en, b_dir, b_oneshot, b_load;
  logic [2:0] b_limit, b_load_val;
  logic [2:0] b_x;
  logic       b_valid, b_step, b_wrap, b_done;
  logic [1:0] b_state_dbg;

  int n_cmp;
  int n_err;

  dec_scan_seq #(.SEL_W(3), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .dir(dir),
    .oneshot(oneshot), .limit(limit), .load(load), .load_val(load_val),
    .X(x), .valid(valid), .step(step), .wrap(wrap), .done(done),
    .state_dbg(state_dbg)
  );

  dec_scan_seq #(.SEL_W(3), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .en(b_en), .dir(b_dir),
    .oneshot(b_oneshot), .limit(b_limit), .load(b_load), .load_val(b_load_val),
    .X(b_x), .valid(b_valid), .step(b_step), .wrap(b_wrap), .done(b_done),
    .state_dbg(b_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ex, input logic ev,
                         input logic es, input logic ew, input logic ed);
    chk({tag, ".X"}, 32'(x), 32'(ex));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".step"}, 32'(step), 32'(es));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ew));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 0; stop = 0; en = 0; dir = 0; oneshot = 0; load = 0;
    limit = 3'd0; load_val = 3'd0;
    b_start = 0; b_stop = 0; b_en = 0; b_dir = 0; b_oneshot = 0; b_load = 0;
    b_limit = 3'd0; b_load_val = 3'd0;

    // reset state
    cyc(2);
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    cyc(1);

    // continuous up scan, limit 7: each value held 4 cycles
    limit = 3'd7; dir = 0; oneshot = 0; en = 1; start = 1;
    cyc(1);
    start = 0;
    chk_out("up.entry", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("up.entry.state", 32'(state_dbg), 32'(S_RUN));
    for (int c = 1; c <= 32; c++) begin
      cyc(1);
      chk_out("up.scan", 3'((c / 4) % 8), 1'b1, (c % 4) == 0,
              ((c % 4) == 0) && (((c / 4) % 8) == 0), 1'b0);
    end
    stop = 1;
    cyc(1);
    stop = 0;
    chk_out("up.stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-run: async, checked between edges
    start = 1;
    cyc(1);
    start = 0;
    cyc(12);
    chk_out("rstmid.pre", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("rstmid.async", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rstmid.state", 32'(state_dbg), 32'(S_IDLE));
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // one-shot down sweep, limit 5: 5,4,3,2,1,0 then 5 with wrap and done
    limit = 3'd5; dir = 1; oneshot = 1; en = 1; start = 1;
    cyc(1);
    start = 0; oneshot = 0;
    chk_out("os.entry", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 23; c++) begin
      cyc(1);
      chk_out("os.scan", 3'(5 - c / 4), 1'b1, (c % 4) == 0, 1'b0, 1'b0);
    end
    cyc(1);
    chk_out("os.done", 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("os.done.state", 32'(state_dbg), 32'(S_DONE));
    cyc(1);
    chk_out("os.idle", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("os.idle.state", 32'(state_dbg), 32'(S_IDLE));
    cyc(2);
    chk_out("os.hold", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // pause at prescaler 2 for 10 cycles, then resume
    limit = 3'd7; dir = 0; en = 1; start = 1;
    cyc(1);
    start = 0;
    cyc(2);
    en = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      chk_out("pause.frozen", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    en = 1;
    cyc(1);
    chk_out("pause.resume1", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_out("pause.resume2", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    stop = 1;
    cyc(1);
    stop = 0;
    chk_out("pause.stop", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(5);
    chk_out("pause.stop_hold", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // out-of-range load, up then down
    limit = 3'd3; dir = 0; start = 1;
    cyc(1);
    start = 0;
    load = 1; load_val = 3'd6;
    cyc(1);
    load = 0;
    chk_out("ld.up.load", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(3);
    chk_out("ld.up.wait", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_out("ld.up.tick", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    dir = 1; load = 1; load_val = 3'd6;
    cyc(1);
    load = 0;
    chk_out("ld.dn.load", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(3);
    chk_out("ld.dn.wait", 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk_out("ld.dn.tick", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // stop and load together in RUN: stop wins, X held
    stop = 1; load = 1; load_val = 3'd5;
    cyc(1);
    stop = 0; load = 0;
    chk_out("col.stop_load", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("col.stop_load.state", 32'(state_dbg), 32'(S_IDLE));

    // start and load together in IDLE: load wins, stays IDLE
    start = 1; load = 1; load_val = 3'd2;
    cyc(1);
    start = 0; load = 0;
    chk_out("col.start_load", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("col.start_load.state", 32'(state_dbg), 32'(S_IDLE));
    cyc(3);
    chk_out("col.start_load.hold", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // PRESCALE=1, limit=0: step and wrap every cycle, X stays 0
    b_limit = 3'd0; b_dir = 0; b_en = 1; b_start = 1;
    cyc(1);
    b_start = 0;
    chk("p1.entry.X", 32'(b_x), 32'd0);
    chk("p1.entry.valid", 32'(b_valid), 32'd1);
    chk("p1.entry.step", 32'(b_step), 32'd0);
    for (int c = 0; c < 6; c++) begin
      cyc(1);
      chk("p1.X", 32'(b_x), 32'd0);
      chk("p1.step", 32'(b_step), 32'd1);
      chk("p1.wrap", 32'(b_wrap), 32'd1);
      chk("p1.done", 32'(b_done), 32'd0);
      chk("p1.state", 32'(b_state_dbg), 32'(S_RUN));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
